// File: rtl/mbist_pkg.sv
// mbist_pkg: shared MBIST types, default widths and March pattern constants
package mbist_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} ana_state_e;

    localparam int SYSTOLIC_SIZE             = 8;
    localparam int PARTIAL_SUM_WIDTH         = 19;
    localparam int ADDR_WIDTH                = 3;
    localparam int MBIST_PATTERN_DEPTH       = 8;
    localparam int MEMORY_PATTERN_ADDR_WIDTH = 3;
    localparam int READ_LATENCY              = 1;
    localparam int FAIL_CNT_WIDTH            = 8;

    localparam logic [PARTIAL_SUM_WIDTH-1:0] MARCH_ZERO = '0;
    localparam logic [PARTIAL_SUM_WIDTH-1:0] MARCH_ONE  = '1;
    localparam logic [PARTIAL_SUM_WIDTH-1:0] MARCH_CHK  = 19'h55555;
    localparam logic [PARTIAL_SUM_WIDTH-1:0] MARCH_ICHK = 19'h2AAAA;

    function automatic logic [PARTIAL_SUM_WIDTH-1:0] march_pattern(input logic [1:0] sel);
        return sel[1] ? (sel[0] ? MARCH_ICHK : MARCH_CHK) : (sel[0] ? MARCH_ONE : MARCH_ZERO);
    endfunction

endpackage

// File: rtl/mbist_expect_delay.sv
// mbist_expect_delay: valid-tagged shift pipeline aligning expected data with memory read latency
module mbist_expect_delay #(
    parameter int WIDTH = 19,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic [DEPTH-1:0]       vld_q, vld_d;
    logic [DEPTH*WIDTH-1:0] dat_q, dat_d;

    // shift one stage per cycle; the newest entry enters at the bottom slot
    always_comb begin
        vld_d = clr ? '0 : DEPTH'({vld_q, in_valid});
        dat_d = clr ? '0 : (DEPTH*WIDTH)'({dat_q, in_data});
    end

    // pipeline stage registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

    assign out_valid = vld_q[DEPTH-1];
    assign out_data  = dat_q[DEPTH*WIDTH-1 -: WIDTH];

endmodule

// File: rtl/mbist_response_analyzer.sv
// mbist_response_analyzer: compares delayed expected words against all memory lanes and logs failures
// Optional feature macro MBIST_FAIL_LOG_EN enables first-fail address/pattern capture.
module mbist_response_analyzer #(
    parameter int SYSTOLIC_SIZE             = mbist_pkg::SYSTOLIC_SIZE,
    parameter int PARTIAL_SUM_WIDTH         = mbist_pkg::PARTIAL_SUM_WIDTH,
    parameter int ADDR_WIDTH                = mbist_pkg::ADDR_WIDTH,
    parameter int MBIST_PATTERN_DEPTH       = mbist_pkg::MBIST_PATTERN_DEPTH,
    parameter int MEMORY_PATTERN_ADDR_WIDTH = mbist_pkg::MEMORY_PATTERN_ADDR_WIDTH,
    parameter int READ_LATENCY              = mbist_pkg::READ_LATENCY,
    parameter int FAIL_CNT_WIDTH            = mbist_pkg::FAIL_CNT_WIDTH
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         start,
    input  logic                                         end_test,
    input  logic                                         rd_en,
    input  logic [ADDR_WIDTH-1:0]                        rd_addr,
    input  logic [MEMORY_PATTERN_ADDR_WIDTH-1:0]         pattern_idx,
    input  logic [PARTIAL_SUM_WIDTH-1:0]                 exp_data,
    input  logic [SYSTOLIC_SIZE*PARTIAL_SUM_WIDTH-1:0]   rd_data,
    output logic                                         busy,
    output logic                                         done,
    output logic                                         fail,
    output logic [SYSTOLIC_SIZE-1:0]                     fail_mem_map,
    output logic [FAIL_CNT_WIDTH-1:0]                    fail_count,
    output logic [ADDR_WIDTH-1:0]                        first_fail_addr,
    output logic [MEMORY_PATTERN_ADDR_WIDTH-1:0]         first_fail_pat
);

    import mbist_pkg::*;

    localparam int DW = $clog2(READ_LATENCY) + 1;
`ifdef MBIST_FAIL_LOG_EN
    localparam int PW = PARTIAL_SUM_WIDTH + ADDR_WIDTH + MEMORY_PATTERN_ADDR_WIDTH;
`else
    localparam int PW = PARTIAL_SUM_WIDTH;
`endif

    ana_state_e                      state_q, state_d;
    logic [DW-1:0]                   drain_q, drain_d;
    logic                            busy_q, busy_d, done_q, done_d;
    logic [SYSTOLIC_SIZE-1:0]        map_q, map_d, lane_mm;
    logic [FAIL_CNT_WIDTH-1:0]       cnt_q, cnt_d;
    logic [PW-1:0]                   pay_in, pay_out;
    logic [PARTIAL_SUM_WIDTH-1:0]    exp_dly;
    logic                            dly_valid, rd_fail;

`ifdef MBIST_FAIL_LOG_EN
    assign pay_in = {exp_data, rd_addr, pattern_idx};
`else
    logic unused_log;
    assign pay_in     = exp_data;
    assign unused_log = ^{rd_addr, pattern_idx};
`endif

    mbist_expect_delay #(.WIDTH(PW), .DEPTH(READ_LATENCY)) u_delay (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (start),
        .in_valid  (rd_en && state_q == RUN),
        .in_data   (pay_in),
        .out_valid (dly_valid),
        .out_data  (pay_out)
    );

    assign exp_dly = pay_out[PW-1 -: PARTIAL_SUM_WIDTH];

    // per-lane compare in the cycle the tagged read leaves the pipeline
    always_comb begin
        lane_mm = '0;
        for (int i = 0; i < SYSTOLIC_SIZE; i++)
            lane_mm[i] = dly_valid && (rd_data[i*PARTIAL_SUM_WIDTH +: PARTIAL_SUM_WIDTH] != exp_dly);
    end

    assign rd_fail = |lane_mm;

    // next-state of the run control; start wins over end_test, DRAIN lasts READ_LATENCY cycles
    always_comb begin
        state_d = start                ? RUN
                : state_q == RUN       ? (end_test ? DRAIN : RUN)
                : state_q == DRAIN     ? (drain_q == '0 ? DONE : DRAIN)
                : state_q;
        drain_d = state_q == DRAIN ? drain_q - 1'b1 : DW'(READ_LATENCY - 1);
        busy_d  = state_d == RUN || state_d == DRAIN;
        done_d  = state_d == DONE;
    end

    // run-control FSM with registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            drain_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // sticky map and saturating count of failing reads
    always_comb begin
        map_d = start ? '0 : map_q | lane_mm;
        cnt_d = start ? '0 : (rd_fail && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    end

    // result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            map_q <= '0;
            cnt_q <= '0;
        end else begin
            map_q <= map_d;
            cnt_q <= cnt_d;
        end
    end

`ifdef MBIST_FAIL_LOG_EN
    logic [ADDR_WIDTH-1:0]                ffa_q, ffa_d;
    logic [MEMORY_PATTERN_ADDR_WIDTH-1:0] ffp_q, ffp_d;
    logic                                 first_hit;

    // first failure is the one that arrives while no lane has failed yet
    always_comb begin
        first_hit = rd_fail && !(|map_q);
        ffa_d = start ? '0 : first_hit ? pay_out[MEMORY_PATTERN_ADDR_WIDTH +: ADDR_WIDTH] : ffa_q;
        ffp_d = start ? '0 : first_hit ? pay_out[MEMORY_PATTERN_ADDR_WIDTH-1:0] : ffp_q;
    end

    // first-fail location registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ffa_q <= '0;
            ffp_q <= '0;
        end else begin
            ffa_q <= ffa_d;
            ffp_q <= ffp_d;
        end
    end

    assign first_fail_addr = ffa_q;
    assign first_fail_pat  = ffp_q;
`else
    assign first_fail_addr = '0;
    assign first_fail_pat  = '0;
`endif

    assign busy         = busy_q;
    assign done         = done_q;
    assign fail         = |map_q;
    assign fail_mem_map = map_q;
    assign fail_count   = cnt_q;

endmodule

// File: tb/tb_mbist_response_analyzer.sv
// tb_mbist_response_analyzer: two analyzer builds (latency 1/count 8, latency 3/count 4) against a timestamp scoreboard
module tb_mbist_response_analyzer;

    localparam int W = 19;
    localparam int N = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0, end_test = 1'b0, rd_en = 1'b0;
    logic [2:0]       rd_addr = '0, pattern_idx = '0;
    logic [W-1:0]     exp_data = '0;
    logic [N*W-1:0]   word = '0;
    logic [N*W-1:0]   wp0 = '0, wp1 = '0, wp2 = '0;

    logic       busy_a, done_a, fail_a, busy_b, done_b, fail_b;
    logic [7:0] map_a, map_b, cnt_a;
    logic [3:0] cnt_b;
    logic [2:0] ffa_a, ffp_a, ffa_b, ffp_b;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    // memory return path: word issued with rd_en comes back 1 (a) or 3 (b) cycles later
    always @(posedge clk) begin
        wp0 <= word;
        wp1 <= wp0;
        wp2 <= wp1;
    end

    mbist_response_analyzer #(.READ_LATENCY(1), .FAIL_CNT_WIDTH(8)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start), .end_test(end_test), .rd_en(rd_en),
        .rd_addr(rd_addr), .pattern_idx(pattern_idx), .exp_data(exp_data), .rd_data(wp0),
        .busy(busy_a), .done(done_a), .fail(fail_a), .fail_mem_map(map_a), .fail_count(cnt_a),
        .first_fail_addr(ffa_a), .first_fail_pat(ffp_a)
    );

    mbist_response_analyzer #(.READ_LATENCY(3), .FAIL_CNT_WIDTH(4)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start), .end_test(end_test), .rd_en(rd_en),
        .rd_addr(rd_addr), .pattern_idx(pattern_idx), .exp_data(exp_data), .rd_data(wp2),
        .busy(busy_b), .done(done_b), .fail(fail_b), .fail_mem_map(map_b), .fail_count(cnt_b),
        .first_fail_addr(ffa_b), .first_fail_pat(ffp_b)
    );

    // scoreboard: phase 0 idle, 1 run, 2 drain, 3 done; reads land in a slot keyed by their due edge
    int         ph [2];
    int         dend [2];
    logic [7:0] mmap [2];
    int         mcnt [2];
    logic [2:0] mfa [2], mfp [2];
    logic       pv [2][8];
    logic [7:0] pmm [2][8];
    logic [2:0] pa [2][8], pp [2][8];
    int         lat [2] = '{1, 3};
    int         cmax [2] = '{255, 15};

    task automatic mclear(input int k);
        mmap[k] = '0;
        mcnt[k] = 0;
        mfa[k] = '0;
        mfp[k] = '0;
        for (int s = 0; s < 8; s++) pv[k][s] = 1'b0;
    endtask

    task automatic model_edge(input int k, input logic [7:0] mm);
        int s;
        int ds;
        s = cyc % 8;
        if (start) begin
            mclear(k);
            ph[k] = 1;
        end else begin
            if (pv[k][s]) begin
                if (pmm[k][s] != 0) begin
                    if (mmap[k] == 0) begin
                        mfa[k] = pa[k][s];
                        mfp[k] = pp[k][s];
                    end
                    mmap[k] = mmap[k] | pmm[k][s];
                    if (mcnt[k] < cmax[k]) mcnt[k]++;
                end
                pv[k][s] = 1'b0;
            end
            if (ph[k] == 1 && rd_en) begin
                ds = (cyc + lat[k]) % 8;
                pv[k][ds] = 1'b1;
                pmm[k][ds] = mm;
                pa[k][ds] = rd_addr;
                pp[k][ds] = pattern_idx;
            end
            if (ph[k] == 1 && end_test) begin
                ph[k] = 2;
                dend[k] = cyc + lat[k];
            end else if (ph[k] == 2 && cyc == dend[k]) begin
                ph[k] = 3;
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            mclear(k);
            ph[k] = 0;
            dend[k] = 0;
        end
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int k = 0; k < 2; k++) begin
                    mclear(k);
                    ph[k] = 0;
                end
            end else begin
                logic [7:0] mm;
                for (int i = 0; i < N; i++) mm[i] = word[i*W +: W] != exp_data;
                for (int k = 0; k < 2; k++) model_edge(k, mm);
                cyc++;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int ff_exp(input logic [2:0] v);
`ifdef MBIST_FAIL_LOG_EN
        return int'(v);
`else
        return v == v ? 0 : 1;
`endif
    endfunction

    // per-cycle comparison of both builds against the scoreboard
    initial forever begin
        @(negedge clk);
        chk("busy_a", busy_a, int'(ph[0] == 1 || ph[0] == 2));
        chk("done_a", done_a, int'(ph[0] == 3));
        chk("fail_a", fail_a, int'(mmap[0] != 0));
        chk("map_a", map_a, mmap[0]);
        chk("cnt_a", cnt_a, mcnt[0]);
        chk("ffa_a", ffa_a, ff_exp(mfa[0]));
        chk("ffp_a", ffp_a, ff_exp(mfp[0]));
        chk("busy_b", busy_b, int'(ph[1] == 1 || ph[1] == 2));
        chk("done_b", done_b, int'(ph[1] == 3));
        chk("fail_b", fail_b, int'(mmap[1] != 0));
        chk("map_b", map_b, mmap[1]);
        chk("cnt_b", cnt_b, mcnt[1]);
        chk("ffa_b", ffa_b, ff_exp(mfa[1]));
        chk("ffp_b", ffp_b, ff_exp(mfp[1]));
    end

    // drive one cycle; lanes set in m return exp with bit0 flipped
    task automatic step(input logic s, input logic e, input logic r, input logic [2:0] a,
                        input logic [2:0] p, input logic [W-1:0] x, input logic [7:0] m);
        start = s;
        end_test = e;
        rd_en = r;
        rd_addr = a;
        pattern_idx = p;
        exp_data = x;
        for (int i = 0; i < N; i++) word[i*W +: W] = x ^ (m[i] ? W'(1) : W'(0));
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, '0, 8'h00);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", busy_a, 0);
        chk("rst_map", map_a, 0);
        chk("rst_cnt", cnt_a, 0);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b1, 3'd5, 3'd0, '0, 8'hFF);
        idle(3);
        chk("idle_rd_ignored", map_a, 0);

        step(1'b1, 1'b0, 1'b0, 3'd0, 3'd0, '0, 8'h00);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, 3'(i), 3'd1, 19'h12345 + W'(i * 19'h1111), 8'h00);
        step(1'b0, 1'b1, 1'b0, 3'd0, 3'd0, '0, 8'h00);
        chk("t1_busy_drain", busy_a, 1);
        chk("t1_done_early", done_a, 0);
        idle(1);
        chk("t1_done", done_a, 1);
        chk("t1_map", map_a, 8'h00);
        chk("t1_cnt", cnt_a, 0);
        idle(3);
        chk("t1_done_b", done_b, 1);

        step(1'b1, 1'b0, 1'b0, 3'd0, 3'd0, '0, 8'h00);
        step(1'b0, 1'b0, 1'b1, 3'd1, 3'd0, '0, 8'h00);
        step(1'b0, 1'b0, 1'b1, 3'd5, 3'd0, '0, 8'h08);
        step(1'b0, 1'b0, 1'b1, 3'd6, 3'd0, '0, 8'h00);
        step(1'b0, 1'b1, 1'b0, 3'd0, 3'd0, '0, 8'h00);
        idle(5);
        chk("t2_map", map_a, 8'h08);
        chk("t2_cnt", cnt_a, 1);
        chk("t2_map_b", map_b, 8'h08);
`ifdef MBIST_FAIL_LOG_EN
        chk("t2_ffa", ffa_a, 5);
        chk("t2_ffp", ffp_a, 0);
`endif

        step(1'b1, 1'b0, 1'b0, 3'd0, 3'd0, '0, 8'h00);
        chk("t5_restart_map", map_a, 0);
        chk("t5_restart_busy", busy_a, 1);
        chk("t5_restart_done", done_a, 0);

        step(1'b0, 1'b0, 1'b1, 3'd2, 3'd3, 19'h7FFFF, 8'h81);
        step(1'b0, 1'b0, 1'b1, 3'd3, 3'd3, 19'h7FFFF, 8'h00);
        step(1'b0, 1'b0, 1'b1, 3'd6, 3'd4, 19'h2AAAA, 8'h04);
        step(1'b0, 1'b1, 1'b0, 3'd0, 3'd0, '0, 8'h00);
        idle(5);
        chk("t3_map", map_a, 8'h85);
        chk("t3_cnt", cnt_a, 2);
`ifdef MBIST_FAIL_LOG_EN
        chk("t3_ffa", ffa_a, 2);
        chk("t3_ffp", ffp_a, 3);
`endif

        step(1'b1, 1'b0, 1'b0, 3'd0, 3'd0, '0, 8'h00);
        for (int i = 0; i < 19; i++) step(1'b0, 1'b0, 1'b1, 3'(i), 3'd5, 19'h55555, 8'h10);
        step(1'b0, 1'b1, 1'b1, 3'd7, 3'd6, 19'h0F0F0, 8'h40);
        idle(2);
        chk("t6_done_b_early", done_b, 0);
        idle(1);
        chk("t6_done_b", done_b, 1);
        chk("t6_map_b", map_b, 8'h50);
        chk("t4_cnt_sat", cnt_b, 15);
        chk("t4_cnt_a", cnt_a, 20);

        step(1'b1, 1'b1, 1'b0, 3'd0, 3'd0, '0, 8'h00);
        idle(2);
        chk("start_prio_busy", busy_a, 1);
        chk("start_prio_done", done_a, 0);

        step(1'b0, 1'b0, 1'b1, 3'd4, 3'd2, 19'h00001, 8'h02);
        step(1'b0, 1'b0, 1'b1, 3'd5, 3'd2, 19'h00001, 8'h00);
        chk("t5_pre_rst_map", map_a, 8'h02);
        start = 1'b0;
        end_test = 1'b0;
        rd_en = 1'b0;
        word = '0;
        exp_data = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_map", map_a, 0);
        chk("t5_rst_busy", busy_a, 0);
        chk("t5_rst_cnt", cnt_a, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);
        chk("t5_idle_after_rst", busy_a, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
